// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler: samples sensors each period and runs a valve-lead/pump/valve-lag watering sequence with cooldown
module irrigation_scheduler #(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int SAMPLE_TMO    = 255,
  parameter int BASE_WATER    = 500,
  parameter int HOT_EXTRA     = 250,
  parameter int MAX_ON        = 2000,
  parameter int VALVE_LEAD    = 4,
  parameter int COOLDOWN      = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       manual_req,
  output logic       sample_req,
  input  logic       sensor_valid,
  input  logic [9:0] soil_level,
  input  logic [9:0] temp_level,
  input  logic [9:0] rain_level,
  input  logic [9:0] param_soil_dry,
  input  logic [9:0] param_temp_hot,
  input  logic [9:0] param_rain_yes,
  output logic       valve_open,
  output logic       pump_on,
  output logic       busy,
  output logic [2:0] state_out,
  output logic       sample_timeout,
  output logic [7:0] water_count
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    DECIDE = 3'd2,
    LEAD   = 3'd3,
    WATER  = 3'd4,
    LAG    = 3'd5,
    COOL   = 3'd6
  } state_t;
  localparam logic [15:0] PER_END  = 16'(SAMPLE_PERIOD - 1);
  localparam logic [15:0] TMO_END  = 16'(SAMPLE_TMO - 1);
  localparam logic [15:0] LEAD_END = 16'(VALVE_LEAD - 1);
  localparam logic [15:0] COOL_END = 16'(COOLDOWN - 1);
  localparam logic [15:0] BASE_L   = 16'(BASE_WATER);
  localparam logic [15:0] HOT_L    = 16'(HOT_EXTRA);
  localparam logic [15:0] MAX_L    = 16'(MAX_ON);
  localparam logic [15:0] MAN_DUR  = BASE_L > MAX_L ? MAX_L : BASE_L;
  state_t      state;
  logic [15:0] cnt, dur, want, dur_calc;
  logic [9:0]  soil_q, temp_q, rain_q;
  logic        go_water, rain_now;
  always_comb begin
    want     = BASE_L + (temp_q >= param_temp_hot ? HOT_L : 16'd0);
    dur_calc = want > MAX_L ? MAX_L : want;
  end
  assign go_water  = soil_q < param_soil_dry && rain_q < param_rain_yes;
  assign rain_now  = sensor_valid && rain_level >= param_rain_yes;
  assign state_out = state;
  // Outputs are updated together with each state transition so they always match state_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      dur            <= '0;
      soil_q         <= '0;
      temp_q         <= '0;
      rain_q         <= '0;
      sample_req     <= 1'b0;
      sample_timeout <= 1'b0;
      valve_open     <= 1'b0;
      pump_on        <= 1'b0;
      busy           <= 1'b0;
      water_count    <= '0;
    end else begin
      sample_req     <= 1'b0;
      sample_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (!enable) cnt <= '0;
          else if (manual_req) begin
            dur        <= MAN_DUR;
            cnt        <= '0;
            state      <= LEAD;
            valve_open <= 1'b1;
            busy       <= 1'b1;
          end else if (cnt == PER_END) begin
            cnt        <= '0;
            sample_req <= 1'b1;
            state      <= SAMPLE;
            busy       <= 1'b1;
          end else cnt <= cnt + 16'd1;
        end
        SAMPLE: begin
          if (!enable) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (sensor_valid) begin
            soil_q <= soil_level;
            temp_q <= temp_level;
            rain_q <= rain_level;
            cnt    <= '0;
            state  <= DECIDE;
          end else if (cnt == TMO_END) begin
            cnt            <= '0;
            sample_timeout <= 1'b1;
            state          <= IDLE;
            busy           <= 1'b0;
          end else cnt <= cnt + 16'd1;
        end
        DECIDE: begin
          cnt <= '0;
          if (enable && go_water) begin
            dur        <= dur_calc;
            state      <= LEAD;
            valve_open <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        LEAD: begin
          if (!enable) begin
            cnt        <= '0;
            state      <= IDLE;
            valve_open <= 1'b0;
            busy       <= 1'b0;
          end else if (cnt == LEAD_END) begin
            cnt     <= '0;
            state   <= WATER;
            pump_on <= 1'b1;
          end else cnt <= cnt + 16'd1;
        end
        WATER: begin
          if (!enable || rain_now || cnt + 16'd1 >= dur) begin
            cnt     <= '0;
            state   <= LAG;
            pump_on <= 1'b0;
            if (water_count != 8'hff) water_count <= water_count + 8'd1;
          end else cnt <= cnt + 16'd1;
        end
        LAG: begin
          if (cnt == LEAD_END) begin
            cnt        <= '0;
            state      <= COOL;
            valve_open <= 1'b0;
          end else cnt <= cnt + 16'd1;
        end
        COOL: begin
          if (cnt == COOL_END) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else cnt <= cnt + 16'd1;
        end
        default: begin
          cnt        <= '0;
          state      <= IDLE;
          valve_open <= 1'b0;
          pump_on    <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_irrigation_scheduler.sv
// tb_irrigation_scheduler: directed checks of sampling, watering sequence, aborts, timeout and reset
module tb_irrigation_scheduler;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       manual_req = 1'b0;
  logic       sensor_valid = 1'b0;
  logic [9:0] soil_level = 10'd100;
  logic [9:0] temp_level = 10'd100;
  logic [9:0] rain_level = 10'd0;
  logic [9:0] param_soil_dry = 10'd300;
  logic [9:0] param_temp_hot = 10'd600;
  logic [9:0] param_rain_yes = 10'd500;
  logic       sample_req, valve_open, pump_on, busy, sample_timeout;
  logic [2:0] state_out;
  logic [7:0] water_count;
  logic       d2_sample_req, d2_valve_open, d2_pump_on, d2_busy, d2_sample_timeout;
  logic [2:0] d2_state_out;
  logic [7:0] d2_water_count;
  int vectors = 0;
  int errors = 0;
  int run = 0, pump_len = 0, run2 = 0, pump_len2 = 0;
  int n;

  always #5 clk = ~clk;

  irrigation_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .manual_req(manual_req),
    .sample_req(sample_req), .sensor_valid(sensor_valid),
    .soil_level(soil_level), .temp_level(temp_level), .rain_level(rain_level),
    .param_soil_dry(param_soil_dry), .param_temp_hot(param_temp_hot), .param_rain_yes(param_rain_yes),
    .valve_open(valve_open), .pump_on(pump_on), .busy(busy), .state_out(state_out),
    .sample_timeout(sample_timeout), .water_count(water_count)
  );

  irrigation_scheduler #(.MAX_ON(600)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .manual_req(manual_req),
    .sample_req(d2_sample_req), .sensor_valid(sensor_valid),
    .soil_level(soil_level), .temp_level(temp_level), .rain_level(rain_level),
    .param_soil_dry(param_soil_dry), .param_temp_hot(param_temp_hot), .param_rain_yes(param_rain_yes),
    .valve_open(d2_valve_open), .pump_on(d2_pump_on), .busy(d2_busy), .state_out(d2_state_out),
    .sample_timeout(d2_sample_timeout), .water_count(d2_water_count)
  );

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int lim, output int cycles);
    cycles = 0;
    while (state_out != s && cycles < lim) begin
      tick();
      cycles++;
    end
    check({tag, " reached"}, state_out, s);
  endtask

  task automatic run_len(input logic [2:0] s, output int cycles);
    cycles = 0;
    while (state_out == s && cycles < 5000) begin
      cycles++;
      tick();
    end
  endtask

  // Pump-on pulse widths measured independently of the state encoding.
  always @(negedge clk) begin
    if (pump_on) run++;
    else if (run != 0) begin pump_len = run; run = 0; end
    if (d2_pump_on) run2++;
    else if (run2 != 0) begin pump_len2 = run2; run2 = 0; end
    if (pump_on && !valve_open) check("pump_without_valve", 1, 0);
    if (d2_pump_on && !d2_valve_open) check("pump_without_valve_d2", 1, 0);
  end

  task automatic give_sample();
    sensor_valid = 1'b1;
    tick();
    sensor_valid = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    check("reset state", state_out, 0);
    check("reset outputs", {sample_req, valve_open, pump_on, busy, sample_timeout}, 0);
    check("reset count", water_count, 0);
    reset = 1'b0;
    enable = 1'b1;
    // 1: normal sampled watering
    wait_state("t1 sample", 3'd1, 1100, n);
    check("t1 period", n, 1000);
    check("t1 sample_req", sample_req, 1);
    check("t1 busy", busy, 1);
    give_sample();
    check("t1 decide", state_out, 2);
    check("t1 sample_req pulse", sample_req, 0);
    tick();
    check("t1 lead", state_out, 3);
    check("t1 lead valve/pump", {valve_open, pump_on}, 2'b10);
    run_len(3'd3, n);
    check("t1 lead len", n, 4);
    check("t1 water valve/pump", {valve_open, pump_on}, 2'b11);
    run_len(3'd4, n);
    check("t1 water len", n, 500);
    check("t1 lag valve/pump", {valve_open, pump_on}, 2'b10);
    check("t1 count", water_count, 1);
    run_len(3'd5, n);
    check("t1 lag len", n, 4);
    check("t1 cool", state_out, 6);
    check("t1 cool valve", valve_open, 0);
    run_len(3'd6, n);
    check("t1 cool len", n, 2000);
    check("t1 idle", {state_out, busy}, 0);
    check("t1 pump pulse", pump_len, 500);
    // 2: hot extension, clamped on the MAX_ON=600 instance
    temp_level = 10'd800;
    wait_state("t2 sample", 3'd1, 1100, n);
    check("t2 period", n, 1000);
    give_sample();
    wait_state("t2 lag", 3'd5, 1000, n);
    @(negedge clk);
    #1;
    check("t2 hot pump", pump_len, 750);
    check("t2 clamped pump", pump_len2, 600);
    wait_state("t2 idle", 3'd0, 2100, n);
    check("t2 count", water_count, 2);
    // 3: rain during WATER aborts to LAG
    temp_level = 10'd100;
    wait_state("t3 sample", 3'd1, 1100, n);
    give_sample();
    wait_state("t3 water", 3'd4, 10, n);
    repeat (99) tick();
    rain_level = 10'd900;
    sensor_valid = 1'b1;
    tick();
    sensor_valid = 1'b0;
    rain_level = 10'd0;
    check("t3 lag", state_out, 5);
    check("t3 valve/pump", {valve_open, pump_on}, 2'b10);
    check("t3 count", water_count, 3);
    @(negedge clk);
    #1;
    check("t3 pump pulse", pump_len, 100);
    run_len(3'd5, n);
    check("t3 lag len", n, 4);
    check("t3 valve closed", valve_open, 0);
    wait_state("t3 idle", 3'd0, 2100, n);
    // soil exactly at threshold is not dry
    soil_level = 10'd300;
    wait_state("t3b sample", 3'd1, 1100, n);
    give_sample();
    tick();
    check("t3b no water", state_out, 0);
    check("t3b valve", valve_open, 0);
    // 4: sample timeout
    soil_level = 10'd100;
    wait_state("t4 sample", 3'd1, 1100, n);
    check("t4 period", n, 1000);
    run_len(3'd1, n);
    check("t4 wait len", n, 255);
    check("t4 timeout pulse", sample_timeout, 1);
    check("t4 idle", state_out, 0);
    check("t4 valve", valve_open, 0);
    tick();
    check("t4 pulse width", sample_timeout, 0);
    check("t4 count", water_count, 3);
    // 5: manual watering with wet soil; manual ignored in COOL
    soil_level = 10'd900;
    manual_req = 1'b1;
    tick();
    manual_req = 1'b0;
    check("t5 lead", state_out, 3);
    run_len(3'd3, n);
    check("t5 lead len", n, 4);
    run_len(3'd4, n);
    check("t5 water len", n, 500);
    check("t5 count", water_count, 4);
    run_len(3'd5, n);
    manual_req = 1'b1;
    repeat (3) tick();
    manual_req = 1'b0;
    check("t5 cool holds", state_out, 6);
    check("t5 cool outputs", {valve_open, pump_on}, 0);
    run_len(3'd6, n);
    check("t5 cool rest", n, 1997);
    tick();
    check("t5 not queued", state_out, 0);
    // 6: async reset mid-WATER, then enable drop in WATER and LEAD
    manual_req = 1'b1;
    tick();
    manual_req = 1'b0;
    wait_state("t6 water", 3'd4, 10, n);
    repeat (10) tick();
    #2 reset = 1'b1;
    #1;
    check("t6 reset drive", {valve_open, pump_on}, 0);
    check("t6 reset state", state_out, 0);
    check("t6 reset count", water_count, 0);
    tick();
    reset = 1'b0;
    manual_req = 1'b1;
    tick();
    manual_req = 1'b0;
    wait_state("t6 water2", 3'd4, 10, n);
    repeat (5) tick();
    enable = 1'b0;
    tick();
    check("t6 disable lag", state_out, 5);
    check("t6 disable valve/pump", {valve_open, pump_on}, 2'b10);
    check("t6 disable count", water_count, 1);
    run_len(3'd5, n);
    check("t6 lag len", n, 4);
    check("t6 cool", state_out, 6);
    wait_state("t6 idle", 3'd0, 2100, n);
    enable = 1'b1;
    manual_req = 1'b1;
    tick();
    manual_req = 1'b0;
    check("t6 lead", state_out, 3);
    enable = 1'b0;
    tick();
    check("t6 lead abort", state_out, 0);
    check("t6 lead abort outputs", {valve_open, pump_on, busy}, 0);
    check("t6 lead abort count", water_count, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
